banked_memory_channel: RTL

- Parametrised successor to the single-port behavioural HBM/DDR memory model.
- Word-interleaved across NUM_BANKS banks; ready/valid request and response handshakes with per-bank busy timing, byte-enable writes, and ID-tagged in-order responses.
- Bounded outstanding-request credit with response backpressure.
- Sits between the NMCU memory controller and the testbench or top-level memory, in place of the fixed-latency, always-accepting model.

---
 rtl/banked_memory_channel_if.sv | 36 +++
 rtl/banked_memory_channel.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_memory_channel_if.sv
// Request/response bus between a memory client and banked_memory_channel.
// Latency: none in the bus itself; req_ready is combinational inside the channel.
// Backpressure: producer holds req_* while req_valid && !req_ready; consumer throttles with resp_ready.
interface banked_memory_channel_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic [ID_WIDTH-1:0]     req_id;

    logic                    resp_valid;
    logic                    resp_ready;
    logic                    resp_write;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic [ADDR_WIDTH-1:0]   resp_addr;
    logic [ID_WIDTH-1:0]     resp_id;
    logic                    resp_err;

    // Client side: issues requests, consumes responses
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, req_id, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_rdata, resp_addr, resp_id, resp_err
    );

    // Memory side: accepts requests, produces responses
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, req_id, resp_ready,
        output req_ready, resp_valid, resp_write, resp_rdata, resp_addr, resp_id, resp_err
    );
endinterface

// File: rtl/banked_memory_channel.sv
// banked_memory_channel: word-interleaved banked memory with per-bank busy timing and ID-tagged in-order responses.
// Latency: resp_valid rises LATENCY cycles after the accept edge when the response FIFO is empty.
// Backpressure: req_ready drops when RESP_DEPTH requests are outstanding or the target bank is busy; resp_ready=0 holds the FIFO head.
// Optional macro NMCU_MEM_PERF_CNT_EN adds saturating perf_rd_cnt/perf_wr_cnt/perf_stall_cnt outputs.

// Generic synchronous FIFO with modulo-DEPTH pointers.
// Latency: a pushed entry appears on pop_dat the cycle after its push edge.
// Backpressure: push ignored when full, pop ignored when empty; callers gate with the flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_dat = store[rd_ptr];

    // Pointers wrap at DEPTH so non-power-of-two depths behave correctly
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Entry storage; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module banked_memory_channel #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_SIZE_WORDS = 1024,
    parameter int NUM_BANKS      = 4,
    parameter int LATENCY        = 4,
    parameter int BANK_BUSY      = 2,
    parameter int RESP_DEPTH     = 8,
    parameter int ID_WIDTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    banked_memory_channel_if.slave bus
`ifdef NMCU_MEM_PERF_CNT_EN
    ,
    output logic [31:0]           perf_rd_cnt,
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);
    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BUSY_W    = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;
    localparam int OUT_W     = $clog2(RESP_DEPTH + 1);
    localparam int MEM_AW    = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
    localparam int BE_W      = DATA_WIDTH / 8;

    // Everything a response needs, captured at accept and carried to the consumer
    typedef struct packed {
        logic                  write;
        logic [DATA_WIDTH-1:0] rdata;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ID_WIDTH-1:0]   id;
        logic                  err;
    } resp_t;

    // Word-interleaved banks: bank = low address bits, so a flat array indexed
    // by word address holds exactly the union of all bank arrays.
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE_WORDS];

    logic [BANK_BITS-1:0]  req_bank;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  req_in_range;
    logic                  req_ready_int;
    logic                  accept;
    resp_t                 req_entry;

    logic [BUSY_W-1:0]     bank_busy [NUM_BANKS];
    logic [OUT_W-1:0]      outstanding;

    logic [LATENCY-1:0]    pipe_vld;
    resp_t                 pipe_dat [LATENCY];

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    resp_t                 head_dat;
    resp_t                 resp_view;

    generate
        if (NUM_BANKS > 1) begin : g_bank_sel
            assign req_bank = bus.req_addr[BANK_BITS-1:0];
        end else begin : g_single_bank
            assign req_bank = '0;
        end
    endgenerate

    assign mem_idx      = MEM_AW'(bus.req_addr);
    assign req_in_range = (64'(bus.req_addr) < 64'(MEM_SIZE_WORDS));

    // Credit check plus target-bank availability; no path from resp_ready, so a
    // pop only frees credit for the following cycle.
    assign req_ready_int = (outstanding < OUT_W'(RESP_DEPTH)) && (bank_busy[req_bank] == '0);
    assign bus.req_ready = req_ready_int;
    assign accept        = bus.req_valid && req_ready_int;

    // Build the response record at accept; read data is sampled from the array here
    always_comb begin
        req_entry       = '0;
        req_entry.write = bus.req_write;
        req_entry.addr  = bus.req_addr;
        req_entry.id    = bus.req_id;
        req_entry.err   = !req_in_range;
        if (req_in_range && !bus.req_write) begin
            req_entry.rdata = mem[mem_idx];
        end
    end

    // Byte-masked write at the accept edge; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (accept && bus.req_write && req_in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.req_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Per-bank busy countdown: the accept cycle counts as the first busy cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_busy[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (accept && (req_bank == BANK_BITS'(b))) begin
                    bank_busy[b] <= BUSY_W'(BANK_BUSY - 1);
                end else if (bank_busy[b] != '0) begin
                    bank_busy[b] <= bank_busy[b] - BUSY_W'(1);
                end
            end
        end
    end

    // Outstanding credit: covers both the latency pipe and the response FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, fifo_pop})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Latency pipe valid bits; the pipe never stalls because credit bounds the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
            end
        end
    end

    // Latency pipe payload; stale payload is harmless behind a cleared valid bit
    always_ff @(posedge clk) begin
        pipe_dat[0] <= req_entry;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_dat[k] <= pipe_dat[k-1];
        end
    end

    assign fifo_push = pipe_vld[LATENCY-1] && !fifo_full;
    assign fifo_pop  = !fifo_empty && bus.resp_ready;

    sync_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (pipe_dat[LATENCY-1]),
        .pop      (fifo_pop),
        .pop_dat  (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Outputs present the FIFO head and read as zero whenever nothing is valid,
    // which also makes them zero as soon as reset empties the FIFO.
    assign resp_view      = fifo_empty ? '0 : head_dat;
    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_write = resp_view.write;
    assign bus.resp_rdata = resp_view.rdata;
    assign bus.resp_addr  = resp_view.addr;
    assign bus.resp_id    = resp_view.id;
    assign bus.resp_err   = resp_view.err;

`ifdef NMCU_MEM_PERF_CNT_EN
    // Saturating activity counters for reads, writes and request stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept && !bus.req_write && (perf_rd_cnt != '1)) begin
                perf_rd_cnt <= perf_rd_cnt + 32'd1;
            end
            if (accept && bus.req_write && (perf_wr_cnt != '1)) begin
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
            end
            if (bus.req_valid && !req_ready_int && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif
endmodule
